vga_timing_gen: RTL

//  Parametrised VGA raster timing generator; successor to the fixed 640x480 timer.

---
 rtl/vga_pkg.sv | 14 +
 rtl/clk_en_div.sv | 20 ++
 rtl/vga_timing_gen.sv | 83 ++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing types, standard 640x480 constants and helpers
package vga_pkg;
  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } vga_timing_t;
  localparam vga_timing_t VGA_640x480_H = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam vga_timing_t VGA_640x480_V = '{active: 480, fp: 10, sync: 2, bp: 33};
  function automatic int total(input vga_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction
endpackage

// File: rtl/clk_en_div.sv
// clk_en_div: clock-enable divider, one tick every DIV enabled clocks
module clk_en_div #(
  parameter int DIV = 4,
  localparam int W = DIV > 1 ? $clog2(DIV) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  logic [W-1:0] cnt;
  assign tick = enable && cnt == LAST;
  // count enabled clocks, restart after the tick, hold while disabled
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (tick) cnt <= '0;
    else if (enable) cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with pixel clock-enable
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_640x480_H.active,
  parameter int H_FP     = VGA_640x480_H.fp,
  parameter int H_SYNC   = VGA_640x480_H.sync,
  parameter int H_BP     = VGA_640x480_H.bp,
  parameter int V_ACTIVE = VGA_640x480_V.active,
  parameter int V_FP     = VGA_640x480_V.fp,
  parameter int V_SYNC   = VGA_640x480_V.sync,
  parameter int V_BP     = VGA_640x480_V.bp,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CLK_DIV  = 4,
  localparam int H_TOTAL = total(vga_timing_t'{H_ACTIVE, H_FP, H_SYNC, H_BP}),
  localparam int V_TOTAL = total(vga_timing_t'{V_ACTIVE, V_FP, V_SYNC, V_BP}),
  localparam int XW = $clog2(H_TOTAL),
  localparam int YW = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          pix_ce,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          active_video,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
);
  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_LO  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_HI  = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_LO  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_HI  = YW'(V_ACTIVE + V_FP + V_SYNC);
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || CLK_DIV < 1) begin : g_bad_cfg
    $error("vga_timing_gen: all timing parameters and CLK_DIV must be >= 1");
  end
  logic          tick;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  clk_en_div #(.DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .tick  (tick)
  );
  // next raster position: column wraps at line end, line steps only on that wrap
  always_comb begin
    nx = (x == X_LAST) ? '0 : x + XW'(1);
    ny = (x != X_LAST) ? y : (y == Y_LAST) ? '0 : y + YW'(1);
  end
  // position and decoded outputs move together on the pixel tick, hold otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      x            <= X_LAST;
      y            <= Y_LAST;
      pix_ce       <= 1'b0;
      active_video <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      hsync        <= ~H_POL;
      vsync        <= ~V_POL;
    end else begin
      pix_ce <= tick;
      if (tick) begin
        x            <= nx;
        y            <= ny;
        active_video <= nx < X_ACT && ny < Y_ACT;
        line_start   <= nx == '0;
        frame_start  <= nx == '0 && ny == '0;
        hsync        <= (nx >= HS_LO && nx < HS_HI) ? H_POL : ~H_POL;
        vsync        <= (ny >= VS_LO && ny < VS_HI) ? V_POL : ~V_POL;
      end
    end
  end
endmodule
